wr_pack32: RTL and testbench
============================

Name: wr_pack32

Overview:
- Downstream neighbour of bilinear_core_scalar: consumes its byte-wide output write stream (wr_valid/wr_addr/wr_data).
- Coalesces bytes into 32-bit little-endian words with byte enables and buffers them in a small FIFO.
- Presents the words on a valid/ready master port to a word-wide output memory or DMA.
- Lets the output buffer be 32-bit wide and tolerate write-side backpressure.

Parameters:
- ADDR_W, 32, width of the incoming byte address.
- FIFO_DEPTH, 4, word FIFO entries; power of two, >=2.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  byte write strobe (core wr_valid); no backpressure toward the core.
- in_addr  in  ADDR_W  byte address (core wr_addr).
- in_data  in  8  byte data (core wr_data).
- flush  in  1  one-cycle pulse (tie to core done); emits any partial word.
- m_valid  out  1  FIFO head valid.
- m_ready  in  1  consumer accepts the head.
- m_waddr  out  ADDR_W-2  word address (byte address >> 2).
- m_data  out  32  packed word; lane k = byte address 4*m_waddr + k.
- m_be  out  4  byte enables; bit k set when lane k is written.
- idle  out  1  accumulator empty, FIFO empty and no pending flush.
- overflow  out  1  sticky; set when a word had to be dropped.

Behaviour:
- Reset: sync to clk when rst=1. m_valid=0, m_waddr=0, m_data=0, m_be=0, idle=1, overflow=0. Accumulator, FIFO pointers and flush_pending are cleared. Reset mid-operation discards all held data without emitting it.
- Accumulator registers: acc_valid, acc_waddr, acc_data[31:0], acc_be[3:0].
- in_valid, acc empty:
  - load acc_waddr = in_addr[ADDR_W-1:2];
  - place the byte in lane in_addr[1:0];
  - set the single matching be bit.
- in_valid, acc_valid, same word address: merge the byte into its lane and OR its be bit. A repeated lane overwrites the data, last write wins.
- in_valid, acc_valid, different word address: push the old accumulator to the FIFO, then load the new byte into the accumulator.
- Completion: if the post-merge be equals 4'hF, that word is pushed in the same cycle and the accumulator is cleared.
- flush (acc holds a word, or in_valid is high the same cycle):
  - the merged accumulator is pushed;
  - if that cycle already pushes the old word because of an address change, set flush_pending instead;
  - flush_pending pushes the remaining accumulator next cycle, then clears.
- flush with nothing held: no-op.
- Push rate: at most one FIFO push per cycle.
- Latency: a pushed word is visible on m_* the cycle after the push (registered write, show-ahead read).
- FIFO:
  - pop when m_valid && m_ready;
  - m_data/m_waddr/m_be are held stable while m_valid && !m_ready;
  - push while full succeeds only if a pop occurs the same cycle;
  - otherwise the word is dropped and overflow is set (cleared only by rst);
  - push into empty with m_ready=1 gives m_valid the next cycle (no bypass).
- Counters: rd_ptr/wr_ptr are log2(FIFO_DEPTH)+1 bits and wrap naturally. full = pointer MSBs differ and lower bits are equal.
- idle (combinational): !acc_valid && fifo_empty && !flush_pending.

Decomposition:
- Shared package dsa_pkg holds:
  - PIX_W = 8, WORD_W = 32, BE_W = 4;
  - typedef word_beat_t {waddr, data, be}, the FIFO entry type.
- One natural sub-module: sync_fifo (parameterised width/depth, show-ahead, full/empty). The packer FSM/accumulator stays in wr_pack32.

Test Plan:
- Full word: bytes 0x10,0x11,0x12,0x13 to addr 0..3 on consecutive cycles, m_ready=1. Expect one beat the cycle after the 4th byte: waddr=0, data=0x13121110, be=4'hF. idle=1 afterwards.
- Partial plus flush: bytes 0xAA@5, 0xBB@6, then flush. Expect waddr=1, data=0x00BBAA00 (unwritten lanes 0), be=4'b0110.
- Address break with simultaneous flush: 0x01@8, then 0x02@20 with flush the same cycle. Expect beat {waddr=2, be=4'b0001} then beat {waddr=5, data lane0=0x02, be=4'b0001} on consecutive cycles; flush_pending observed for one cycle.
- Backpressure: m_ready=0 while streaming 16 bytes to addr 0..15 (4 words, FIFO_DEPTH=4). Expect m_valid=1 with beat waddr=0 held stable and overflow=0. Then 4 more bytes to addr 16..19 produce overflow=1. Releasing m_ready drains waddr 0,1,2,3 only.
- Full FIFO with simultaneous pop: FIFO full and m_ready=1 on the cycle a 5th word completes. Expect no drop, overflow stays 0, beat order preserved.
- Reset mid-operation: rst=1 with 2 bytes in the accumulator and 2 FIFO entries. Expect the next cycle m_valid=0, idle=1, overflow=0, and no stale beat after rst is released.

Source files
------------

// File: rtl/dsa_pkg.sv
// Shared types for the write-packing path: byte/word widths and the FIFO entry
// that carries one coalesced 32-bit word with its byte enables.
package dsa_pkg;

  localparam int PIX_W   = 8;
  localparam int WORD_W  = 32;
  localparam int BE_W    = 4;
  // Widest word address carried in a FIFO entry (32-bit byte address >> 2).
  localparam int WADDR_W = 30;

  typedef struct packed {
    logic [WADDR_W-1:0] waddr;
    logic [WORD_W-1:0]  data;
    logic [BE_W-1:0]    be;
  } word_beat_t;

endpackage

// File: rtl/wr_pack32_if.sv
// Word-wide valid/ready write port from the packer to an output memory or DMA.
interface wr_pack32_if #(
  parameter int ADDR_W = 32
);
  import dsa_pkg::*;

  logic                m_valid;
  logic                m_ready;
  logic [ADDR_W-3:0]   m_waddr;
  logic [WORD_W-1:0]   m_data;
  logic [BE_W-1:0]     m_be;

  modport master (
    output m_valid, m_waddr, m_data, m_be,
    input  m_ready
  );

  modport slave (
    input  m_valid, m_waddr, m_data, m_be,
    output m_ready
  );

endinterface

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; a push while full is accepted only when a pop
// frees the head slot in the same cycle. The head reads as zero when empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_rd = pop && !empty;
  assign do_wr = push && (!full || do_rd);
  assign dout  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // NOTE: state updates use non-blocking assignment so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately left out of reset; the pointers define which
  // entries are live and the empty gate on dout hides stale contents.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/wr_pack32.sv
// Coalesces a byte write stream into little-endian 32-bit words with byte
// enables and queues them for a word-wide valid/ready consumer.
module wr_pack32
  import dsa_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [PIX_W-1:0]  in_data,
  input  logic              flush,
  wr_pack32_if.master       m,
  output logic              idle,
  output logic              overflow
);

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-3:0] waddr;
    logic [WORD_W-1:0] data;
    logic [BE_W-1:0]   be;
  } acc_t;

  acc_t              acc_q, acc_d;
  logic              flush_pending, pending_d;
  logic              overflow_q;
  logic              push;
  word_beat_t        push_beat, head;
  logic              fifo_full, fifo_empty, pop;
  logic [ADDR_W-3:0] in_waddr;
  logic [1:0]        lane;

  assign in_waddr = in_addr[ADDR_W-1:2];
  assign lane     = in_addr[1:0];

  function automatic word_beat_t to_beat(input acc_t a);
    word_beat_t b;
    b.waddr = WADDR_W'(a.waddr);
    b.data  = a.data;
    b.be    = a.be;
    return b;
  endfunction

  // Each branch empties the accumulator when it pushes, so at most one of the
  // pending, address-break and completion pushes can fire in a cycle.
  // NOTE: every combinational output gets a default first so no path leaves
  // a signal unassigned and infers a latch.
  always_comb begin
    acc_d     = acc_q;
    push      = 1'b0;
    push_beat = '0;
    pending_d = 1'b0;

    if (flush_pending && acc_d.valid) begin
      push      = 1'b1;
      push_beat = to_beat(acc_d);
      acc_d     = '0;
    end

    if (in_valid) begin
      if (acc_d.valid && acc_d.waddr != in_waddr) begin
        push      = 1'b1;
        push_beat = to_beat(acc_d);
        acc_d     = '0;
      end
      if (!acc_d.valid) begin
        acc_d.valid = 1'b1;
        acc_d.waddr = in_waddr;
      end
      acc_d.data[{lane, 3'b000} +: PIX_W] = in_data;
      acc_d.be[lane]                      = 1'b1;
      if (acc_d.be == 4'hF) begin
        push      = 1'b1;
        push_beat = to_beat(acc_d);
        acc_d     = '0;
      end
    end

    // A flush that collides with an address-break push defers by one cycle.
    if (flush && acc_d.valid) begin
      if (push) begin
        pending_d = 1'b1;
      end else begin
        push      = 1'b1;
        push_beat = to_beat(acc_d);
        acc_d     = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q         <= '0;
      flush_pending <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      acc_q         <= acc_d;
      flush_pending <= pending_d;
      if (push && fifo_full && !pop) overflow_q <= 1'b1;
    end
  end

  assign pop = m.m_valid && m.m_ready;

  sync_fifo #(
    .WIDTH ($bits(word_beat_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_beat),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign m.m_valid = !fifo_empty;
  assign m.m_waddr = head.waddr[ADDR_W-3:0];
  assign m.m_data  = head.data;
  assign m.m_be    = head.be;
  assign idle      = !acc_q.valid && fifo_empty && !flush_pending;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_wr_pack32.sv
// Directed bench for wr_pack32: expected beats are queued at stimulus time and
// a negedge monitor pops and compares each accepted beat.
module tb_wr_pack32;
  import dsa_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_addr;
  logic [7:0]  in_data;
  logic        flush;
  logic        idle;
  logic        overflow;

  int n_checks = 0;
  int n_pass   = 0;

  word_beat_t exp_q[$];

  wr_pack32_if #(.ADDR_W(32)) bus ();

  wr_pack32 #(.ADDR_W(32), .FIFO_DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_addr  (in_addr),
    .in_data  (in_data),
    .flush    (flush),
    .m        (bus),
    .idle     (idle),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [65:0] actual, input logic [65:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, actual, expected);
  endtask

  function automatic word_beat_t mk(input int waddr, input logic [31:0] data, input logic [3:0] be);
    word_beat_t b;
    b.waddr = WADDR_W'(waddr);
    b.data  = data;
    b.be    = be;
    return b;
  endfunction

  // Monitor: every accepted beat must match the head of the expected queue.
  initial begin
    word_beat_t got, want;
    forever begin
      @(negedge clk);
      if (!rst && bus.m_valid && bus.m_ready) begin
        got = mk(int'(bus.m_waddr), bus.m_data, bus.m_be);
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_beat: got %h expected none", got);
        end else begin
          want = exp_q.pop_front();
          check("beat", got, want);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(input logic [31:0] addr, input logic [7:0] data, input logic fl);
    in_valid = 1'b1;
    in_addr  = addr;
    in_data  = data;
    flush    = fl;
    step();
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  // Four bytes base..base+3 to one aligned word; optionally queue the beat.
  task automatic send_word(input int waddr, input logic [7:0] base, input logic expect_beat);
    for (int k = 0; k < 4; k++) send(32'(4 * waddr + k), base + 8'(k), 1'b0);
    if (expect_beat)
      exp_q.push_back(mk(waddr, {base + 8'd3, base + 8'd2, base + 8'd1, base}, 4'hF));
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    step();
    check("rst_m_valid", 66'(bus.m_valid), 66'd0);
    check("rst_m_outs", {bus.m_waddr, bus.m_data, bus.m_be}, 66'd0);
    check("rst_idle", 66'(idle), 66'd1);
    check("rst_overflow", 66'(overflow), 66'd0);
    rst = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_addr     = '0;
    in_data     = '0;
    flush       = 1'b0;
    bus.m_ready = 1'b1;
    step();
    apply_reset();

    // Full word on consecutive cycles.
    send(32'd0, 8'h10, 1'b0);
    send(32'd1, 8'h11, 1'b0);
    send(32'd2, 8'h12, 1'b0);
    exp_q.push_back(mk(0, 32'h1312_1110, 4'hF));
    send(32'd3, 8'h13, 1'b0);
    check("full_word_visible", 66'(bus.m_valid), 66'd1);
    wait_cycles(2);
    check("full_word_idle", 66'(idle), 66'd1);

    // Partial word emitted by flush.
    send(32'd5, 8'hAA, 1'b0);
    send(32'd6, 8'hBB, 1'b0);
    check("partial_not_idle", 66'(idle), 66'd0);
    exp_q.push_back(mk(1, 32'h00BB_AA00, 4'b0110));
    in_valid = 1'b0;
    flush    = 1'b1;
    step();
    flush = 1'b0;
    wait_cycles(2);
    check("partial_idle", 66'(idle), 66'd1);

    // Address break with flush in the same cycle defers the second push.
    send(32'd8, 8'h01, 1'b0);
    exp_q.push_back(mk(2, 32'h0000_0001, 4'b0001));
    exp_q.push_back(mk(5, 32'h0000_0002, 4'b0001));
    send(32'd20, 8'h02, 1'b1);
    check("pending_set", 66'(dut.flush_pending), 66'd1);
    step();
    check("pending_clear", 66'(dut.flush_pending), 66'd0);
    wait_cycles(3);
    check("break_idle", 66'(idle), 66'd1);

    // Backpressure: fill the FIFO, then drop a fifth word.
    bus.m_ready = 1'b0;
    for (int w = 0; w < 4; w++) send_word(w, 8'h20 + 8'(4 * w), 1'b1);
    check("bp_valid", 66'(bus.m_valid), 66'd1);
    check("bp_head", {bus.m_waddr, bus.m_data, bus.m_be}, {30'd0, 32'h2322_2120, 4'hF});
    check("bp_no_overflow", 66'(overflow), 66'd0);
    send_word(4, 8'h30, 1'b0);
    check("bp_overflow", 66'(overflow), 66'd1);
    check("bp_head_stable", {bus.m_waddr, bus.m_data, bus.m_be}, {30'd0, 32'h2322_2120, 4'hF});
    bus.m_ready = 1'b1;
    wait_cycles(6);
    check("bp_drained_idle", 66'(idle), 66'd1);
    check("bp_overflow_sticky", 66'(overflow), 66'd1);

    // Full FIFO with a pop in the cycle the fifth word completes.
    apply_reset();
    bus.m_ready = 1'b0;
    for (int w = 8; w < 12; w++) send_word(w, 8'(4 * w), 1'b1);
    send(32'd48, 8'd48, 1'b0);
    send(32'd49, 8'd49, 1'b0);
    send(32'd50, 8'd50, 1'b0);
    exp_q.push_back(mk(12, {8'd51, 8'd50, 8'd49, 8'd48}, 4'hF));
    bus.m_ready = 1'b1;
    send(32'd51, 8'd51, 1'b0);
    check("simul_no_overflow", 66'(overflow), 66'd0);
    wait_cycles(7);
    check("simul_overflow_final", 66'(overflow), 66'd0);
    check("simul_idle", 66'(idle), 66'd1);

    // Reset mid-operation discards FIFO entries and the accumulator.
    bus.m_ready = 1'b0;
    send_word(0, 8'h40, 1'b0);
    send_word(1, 8'h44, 1'b0);
    send(32'd8, 8'h48, 1'b0);
    send(32'd9, 8'h49, 1'b0);
    check("pre_rst_busy", 66'(idle), 66'd0);
    apply_reset();
    bus.m_ready = 1'b1;
    wait_cycles(6);
    check("post_rst_no_valid", 66'(bus.m_valid), 66'd0);
    check("post_rst_idle", 66'(idle), 66'd1);

    check("queue_drained", 66'(exp_q.size()), 66'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
